// File: rtl/clk_gen_pkg.sv
// Shared widths, state encoding and phase-length helper for the clk_gen_ctrl divider.
package clk_gen_pkg;

    localparam int unsigned DIV_W       = 8;
    localparam int unsigned DEFAULT_DIV = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_HI = 2'd1,
        RUN_LO = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } phase_len_t;

    // High phase takes the extra cycle of an odd period.
    function automatic phase_len_t phase_len(input logic [31:0] n);
        phase_len_t len;
        len.lo = n >> 1;
        len.hi = n - len.lo;
        return len;
    endfunction

endpackage

// File: rtl/clk_gen_phase_cnt.sv
// Loadable down-counter timing one clk_out phase; zero flags the last cycle of the phase.
module clk_gen_phase_cnt import clk_gen_pkg::*; #(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/clk_gen_ctrl.sv
// Programmable clock divider: run/stop FSM, ratio handshake with pending register,
// and period-boundary-only updates so clk_out never shows a truncated phase.
module clk_gen_ctrl #(
    parameter int unsigned DIV_W       = clk_gen_pkg::DIV_W,
    parameter int unsigned DEFAULT_DIV = clk_gen_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] cur_div
);
    import clk_gen_pkg::*;

    state_e           state, state_nxt;
    logic [DIV_W-1:0] cur_div_nxt;
    logic [DIV_W-1:0] pend_div;
    logic             pend_vld, pend_vld_nxt;
    logic             clk_out_nxt, tick_nxt, cfg_err_nxt;

    logic             xfer, xfer_ok;
    logic [DIV_W-1:0] eff_div, sel_div;
    phase_len_t       len;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [DIV_W-1:0] cnt_load_val, cnt;

    clk_gen_phase_cnt #(.W(DIV_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign cfg_ready = !pend_vld;
    assign running   = (state != IDLE);
    assign xfer      = cfg_valid && !pend_vld;
    assign xfer_ok   = xfer && (cfg_div >= DIV_W'(2));

    // Ratio that governs the next period once any pending value is folded in.
    assign eff_div = pend_vld ? pend_div : cur_div;
    assign sel_div = (state == RUN_HI) ? cur_div : eff_div;
    assign len     = phase_len(32'(sel_div));

    always_comb begin
        state_nxt    = state;
        cur_div_nxt  = cur_div;
        pend_vld_nxt = pend_vld;
        clk_out_nxt  = clk_out;
        tick_nxt     = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;

        case (state)
            IDLE: begin
                clk_out_nxt  = 1'b0;
                cur_div_nxt  = eff_div;
                pend_vld_nxt = 1'b0;
                if (en) begin
                    state_nxt    = RUN_HI;
                    clk_out_nxt  = 1'b1;
                    tick_nxt     = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = DIV_W'(len.hi - 32'd1);
                end
            end
            RUN_HI: begin
                if (cnt_zero) begin
                    state_nxt    = RUN_LO;
                    clk_out_nxt  = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = DIV_W'(len.lo - 32'd1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RUN_LO: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    cur_div_nxt  = eff_div;
                    pend_vld_nxt = 1'b0;
                    if (en) begin
                        state_nxt    = RUN_HI;
                        clk_out_nxt  = 1'b1;
                        tick_nxt     = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = DIV_W'(len.hi - 32'd1);
                    end else begin
                        state_nxt   = IDLE;
                        clk_out_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                clk_out_nxt = 1'b0;
            end
        endcase

        // Acceptance only happens with nothing pending, so this never races the clear above.
        if (xfer_ok) begin
            pend_vld_nxt = 1'b1;
        end
        cfg_err_nxt = xfer && !xfer_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_div  <= DIV_W'(DEFAULT_DIV);
            pend_vld <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur_div  <= cur_div_nxt;
            pend_vld <= pend_vld_nxt;
            clk_out  <= clk_out_nxt;
            tick     <= tick_nxt;
            cfg_err  <= cfg_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer_ok) begin
            pend_div <= cfg_div;
        end
    end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Bench for clk_gen_ctrl: directed scenarios plus random traffic against a period-position model.
module tb_clk_gen_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready, cfg_err, clk_out, tick, running;
    logic [7:0] cur_div;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_gen_ctrl #(.DIV_W(8), .DEFAULT_DIV(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running),
        .cur_div   (cur_div)
    );

    // Model: position inside the current period, the ratio of that period, and a pending slot.
    bit m_run, m_pend, m_tick, m_err;
    int m_pos, m_div = 10, m_pdiv;

    task automatic model_edge(input bit r, input bit e, input bit v, input int d);
        bit x;
        if (r) begin
            m_run = 0; m_pend = 0; m_tick = 0; m_err = 0; m_pos = 0; m_div = 10;
            return;
        end
        x = v && !m_pend;
        m_tick = 0;
        if (!m_run) begin
            if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
            if (e) begin m_run = 1; m_pos = 0; m_tick = 1; end
        end else if (m_pos == m_div - 1) begin
            if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
            if (e) begin m_pos = 0; m_tick = 1; end
            else m_run = 0;
        end else begin
            m_pos++;
        end
        m_err = x && (d < 2);
        if (x && d >= 2) begin m_pend = 1; m_pdiv = d; end
    endtask

    function automatic logic [12:0] exp_vec();
        bit hi;
        hi = m_run && (m_pos < m_div - m_div / 2);
        return {hi, m_tick, !m_pend, m_err, m_run, 8'(m_div)};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {clk_out, tick, cfg_ready, cfg_err, running, cur_div};
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input int d);
        rst = r; en = e; cfg_valid = v; cfg_div = 8'(d);
        @(posedge clk);
        model_edge(r, e, v, d);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] rv;
        rv = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10};
        step(1, 1'($urandom), 1'($urandom), 2);
        step(1, 1, 1, 0);
        total++;
        if (dut_vec() !== rv) begin
            bad++; $display("FAIL reset got=%h want=%h", dut_vec(), rv);
        end
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_model got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_default_run();
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 0, 0);
            total++;
            if (clk_out !== ((i % 10) < 5) || tick !== ((i % 10) == 0)) begin
                bad++; $display("FAIL default_run i=%0d got clk_out=%b tick=%b want clk_out=%b tick=%b",
                                i, clk_out, tick, (i % 10) < 5, (i % 10) == 0);
            end
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL default_run_model i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_cfg_idle();
        for (int i = 0; i < 300 && running; i++) begin
            step(0, 0, 0, 0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL stop_to_idle i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        total++;
        if (running !== 1'b0) begin
            bad++; $display("FAIL stop_timeout got running=%b want 0", running);
        end
        step(0, 0, 1, 3);
        total++;
        if (cfg_ready !== 1'b0 || cur_div !== 8'd10) begin
            bad++; $display("FAIL cfg_idle_accept got ready=%b cur_div=%0d want ready=0 cur_div=10", cfg_ready, cur_div);
        end
        step(0, 0, 0, 0);
        total++;
        if (cfg_ready !== 1'b1 || cur_div !== 8'd3) begin
            bad++; $display("FAIL cfg_idle_apply got ready=%b cur_div=%0d want ready=1 cur_div=3", cfg_ready, cur_div);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0);
            total++;
            if (clk_out !== ((i % 3) < 2) || dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL n3_pattern i=%0d got clk_out=%b vec=%h want clk_out=%b vec=%h",
                                i, clk_out, dut_vec(), (i % 3) < 2, exp_vec());
            end
        end
    endtask

    task automatic test_cfg_midrun();
        bit   w_clk, w_rdy;
        logic [7:0] w_div;
        step(1, 0, 0, 0);
        for (int i = 0; i < 22; i++) begin
            step(0, 1, (i >= 2 && i <= 8), (i == 2) ? 4 : 7);
            w_clk = (i < 10) ? (i < 5) : (((i - 10) % 4) < 2);
            w_rdy = (i < 2) || (i >= 10);
            w_div = (i >= 10) ? 8'd4 : 8'd10;
            total++;
            if (clk_out !== w_clk || cfg_ready !== w_rdy || cur_div !== w_div) begin
                bad++; $display("FAIL midrun i=%0d got clk_out=%b ready=%b cur_div=%0d want %b %b %0d",
                                i, clk_out, cfg_ready, cur_div, w_clk, w_rdy, w_div);
            end
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL midrun_model i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_cfg_err();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, (i % 2) == 0, (i == 0) ? 1 : 0);
            total++;
            if (cfg_err !== ((i % 2) == 0) || cfg_ready !== 1'b1 || cur_div !== 8'd4) begin
                bad++; $display("FAIL cfg_err i=%0d got err=%b ready=%b cur_div=%0d want err=%b ready=1 cur_div=4",
                                i, cfg_err, cfg_ready, cur_div, (i % 2) == 0);
            end
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL cfg_err_model i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stop();
        step(1, 0, 0, 0);
        step(0, 0, 1, 8);
        step(0, 0, 0, 0);
        total++;
        if (cur_div !== 8'd8) begin
            bad++; $display("FAIL stop_cfg got cur_div=%0d want 8", cur_div);
        end
        for (int j = 0; j < 11; j++) begin
            step(0, (j == 0), 0, 0);
            total++;
            if (clk_out !== (j < 4) || running !== (j < 8) || dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL stop_drain j=%0d got clk_out=%b running=%b vec=%h want %b %b vec=%h",
                                j, clk_out, running, dut_vec(), j < 4, j < 8, exp_vec());
            end
        end
        for (int j = 0; j < 17; j++) begin
            step(0, (j == 0 || j == 8), 0, 0);
            total++;
            if (tick !== (j == 0 || j == 8) || clk_out !== ((j % 8) < 4 && j < 16) || running !== (j < 16)) begin
                bad++; $display("FAIL no_gap j=%0d got tick=%b clk_out=%b running=%b", j, tick, clk_out, running);
            end
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL no_gap_model j=%0d got=%h want=%h", j, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [12:0] rv;
        rv = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10};
        for (int j = 0; j < 6; j++) step(0, 1, (j == 4), 5);
        total++;
        if (clk_out !== 1'b0 || cfg_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_setup got clk_out=%b ready=%b want 0 0", clk_out, cfg_ready);
        end
        step(1, 1, 0, 0);
        total++;
        if (dut_vec() !== rv) begin
            bad++; $display("FAIL rst_mid got=%h want=%h", dut_vec(), rv);
        end
        step(0, 0, 0, 0);
        total++;
        if (cur_div !== 8'd10 || cfg_ready !== 1'b1 || dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL rst_mid_after got cur_div=%0d ready=%b vec=%h want 10 1 vec=%h",
                            cur_div, cfg_ready, dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit r, e, v;
        int d;
        bit en_lvl = 1;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 250) == 0;
            if (($urandom % 16) == 0) en_lvl = !en_lvl;
            e = en_lvl;
            v = ($urandom % 5) == 0;
            case ($urandom % 8)
                0: d = 0;
                1: d = 1;
                2: d = 2;
                3: d = 3;
                default: d = (($urandom % 40) == 0) ? 255 : $urandom_range(2, 20);
            endcase
            step(r, e, v, d);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL random i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        test_reset();
        test_default_run();
        test_cfg_idle();
        test_cfg_midrun();
        test_cfg_err();
        test_stop();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
